// File: rtl/fp32_pkg.sv
// Shared FP32 constants, accumulator state encoding and small field helpers.
package fp32_pkg;

  localparam logic [31:0] FP32_ZERO    = 32'h0000_0000;
  localparam logic [31:0] FP32_QNAN    = 32'hFF80_0001;
  localparam logic [31:0] FP32_ADD_NAN = 32'h7FC0_0000;
  localparam logic [7:0]  FP32_EXP_MAX = 8'hFF;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } acc_state_t;

  function automatic logic fp32_is_nan(input logic [31:0] v);
    return (v[30:23] == FP32_EXP_MAX) && (v[22:0] != 23'd0);
  endfunction

  function automatic logic fp32_is_inf(input logic [31:0] v);
    return (v[30:23] == FP32_EXP_MAX) && (v[22:0] == 23'd0);
  endfunction

  function automatic logic [4:0] fp32_lzc27(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(26 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/fp32_stream_accumulator_final.sv
// Combinational FP32 adder/subtractor: round-to-nearest-even, subnormals flushed to zero.
// Result = NumberA + (A_S ? -NumberB : NumberB); any NaN operand or inf-inf yields a quiet NaN.
module Final
  import fp32_pkg::*;
(
  input  logic [31:0] NumberA,
  input  logic [31:0] NumberB,
  input  logic        A_S,
  output logic [31:0] Result
);

  logic        w_sa, w_sb, w_swap, w_s_big, w_s_sml, w_sticky, w_rup;
  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic [7:0]  w_e_big, w_e_sml, w_d;
  logic [26:0] w_m_big, w_m_sml, w_m_shf, w_norm;
  logic [27:0] w_raw;
  logic [24:0] w_rnd;
  logic [22:0] w_frac;
  logic [4:0]  w_lz;
  logic signed [9:0] w_exp_n, w_exp_r;

  always_comb begin
    w_sa     = NumberA[31];
    w_sb     = NumberB[31] ^ A_S;
    w_a_nan  = fp32_is_nan(NumberA);
    w_b_nan  = fp32_is_nan(NumberB);
    w_a_inf  = fp32_is_inf(NumberA);
    w_b_inf  = fp32_is_inf(NumberB);
    w_a_zero = (NumberA[30:23] == 8'd0);
    w_b_zero = (NumberB[30:23] == 8'd0);

    // Order operands by magnitude so the subtraction below never goes negative.
    w_swap  = NumberB[30:0] > NumberA[30:0];
    w_s_big = w_swap ? w_sb : w_sa;
    w_s_sml = w_swap ? w_sa : w_sb;
    w_e_big = w_swap ? NumberB[30:23] : NumberA[30:23];
    w_e_sml = w_swap ? NumberA[30:23] : NumberB[30:23];
    w_m_big = {1'b1, (w_swap ? NumberB[22:0] : NumberA[22:0]), 3'b000};
    w_m_sml = {1'b1, (w_swap ? NumberA[22:0] : NumberB[22:0]), 3'b000};
    w_d     = w_e_big - w_e_sml;

    w_sticky = 1'b0;
    w_m_shf  = 27'd1;
    if (w_d < 8'd27) begin
      w_m_shf    = w_m_sml >> w_d;
      w_sticky   = |(w_m_sml & ~({27{1'b1}} << w_d));
      w_m_shf[0] = w_m_shf[0] | w_sticky;
    end

    if (w_s_big == w_s_sml) w_raw = {1'b0, w_m_big} + {1'b0, w_m_shf};
    else                    w_raw = {1'b0, w_m_big} - {1'b0, w_m_shf};

    w_lz    = fp32_lzc27(w_raw[26:0]);
    w_exp_n = signed'({2'b00, w_e_big});
    if (w_raw[27]) begin
      w_norm  = w_raw[27:1] | {26'd0, w_raw[0]};
      w_exp_n = w_exp_n + 10'sd1;
    end else begin
      w_norm  = w_raw[26:0] << w_lz;
      w_exp_n = w_exp_n - signed'({5'd0, w_lz});
    end

    // Guard at bit 2; round/sticky below it; lsb of the kept mantissa is bit 3.
    w_rup   = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_rnd   = {1'b0, w_norm[26:3]} + {24'd0, w_rup};
    w_frac  = w_rnd[24] ? w_rnd[23:1] : w_rnd[22:0];
    w_exp_r = w_rnd[24] ? (w_exp_n + 10'sd1) : w_exp_n;

    if (w_raw == 28'd0)            Result = FP32_ZERO;
    else if (w_exp_r >= 10'sd255)  Result = {w_s_big, FP32_EXP_MAX, 23'd0};
    else if (w_exp_r <= 10'sd0)    Result = {w_s_big, 31'd0};
    else                           Result = {w_s_big, w_exp_r[7:0], w_frac};

    if (w_a_nan || w_b_nan)        Result = FP32_ADD_NAN;
    else if (w_a_inf && w_b_inf)   Result = (w_sa != w_sb) ? FP32_ADD_NAN
                                                           : {w_sa, FP32_EXP_MAX, 23'd0};
    else if (w_a_inf)              Result = {w_sa, FP32_EXP_MAX, 23'd0};
    else if (w_b_inf)              Result = {w_sb, FP32_EXP_MAX, 23'd0};
    else if (w_a_zero && w_b_zero) Result = {w_sa & w_sb, 31'd0};
    else if (w_a_zero)             Result = {w_sb, NumberB[30:0]};
    else if (w_b_zero)             Result = {w_sa, NumberA[30:0]};
  end

endmodule

// File: rtl/fp32_stream_accumulator.sv
// Streaming FP32 accumulator: one operand per cycle, result valid 1 cycle after the last beat.
// While a result is held (out_valid) in_ready is low until out_ready drains it; clr overrides all.
module fp32_stream_accumulator
  import fp32_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_data,
  input  logic               in_sub,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_sum,
  output logic [COUNT_W-1:0] out_count,
  output logic [2:0]         out_flags
);

  acc_state_t         r_state;
  logic [31:0]        r_acc;
  logic [COUNT_W-1:0] r_count;
  logic [2:0]         r_flags;

  logic [31:0]        w_result;
  logic [31:0]        w_acc_next;
  logic               w_nan_next;
  logic [COUNT_W-1:0] w_count_next;

  Final u_adder (
    .NumberA (r_acc),
    .NumberB (in_data),
    .A_S     (in_sub),
    .Result  (w_result)
  );

  // Once a NaN appears it is pinned to the canonical pattern for the rest of the sequence.
  assign w_nan_next   = r_flags[2] | fp32_is_nan(w_result);
  assign w_acc_next   = w_nan_next ? FP32_QNAN : w_result;
  assign w_count_next = (r_count == {COUNT_W{1'b1}}) ? r_count
                                                    : r_count + {{(COUNT_W-1){1'b0}}, 1'b1};

  assign in_ready  = (r_state == ST_ACCUM) && !clr;
  assign out_valid = (r_state == ST_HOLD);
  assign out_sum   = r_acc;
  assign out_count = r_count;
  assign out_flags = r_flags;

  // Flags are captured with each accepted beat so they describe the held sum and read 0 when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ACCUM;
      r_acc   <= FP32_ZERO;
      r_count <= '0;
      r_flags <= 3'b000;
    end else if (clr) begin
      r_state <= ST_ACCUM;
      r_acc   <= FP32_ZERO;
      r_count <= '0;
      r_flags <= 3'b000;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (in_valid) begin
            r_acc   <= w_acc_next;
            r_count <= w_count_next;
            r_flags <= {w_nan_next, fp32_is_inf(w_acc_next), (w_acc_next[30:0] == 31'd0)};
            if (in_last) r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_state <= ST_ACCUM;
            r_acc   <= FP32_ZERO;
            r_count <= '0;
            r_flags <= 3'b000;
          end
        end
        default: r_state <= ST_ACCUM;
      endcase
    end
  end

endmodule

// File: doc/fp32_stream_accumulator.md
FP32_STREAM_ACCUMULATOR -- requirements
Module: fp32_stream_accumulator

Interface
REQ-001 SHALL have parameter COUNT_W, default 16, width of the accepted-operand counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port clr  input  1  synchronous clear of the accumulation.
REQ-005 SHALL have port in_valid  input  1  operand present.
REQ-006 SHALL have port in_ready  output  1  operand accepted this cycle when in_valid is also high.
REQ-007 SHALL have port in_data  input  32  IEEE-754 single-precision operand.
REQ-008 SHALL have port in_sub  input  1  0 = add operand, 1 = subtract operand; drives the adder A_S input.
REQ-009 SHALL have port in_last  input  1  marks the final operand of a sequence.
REQ-010 SHALL have port out_valid  output  1  sequence result present.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port out_sum  output  32  accumulated FP32 result.
REQ-013 SHALL have port out_count  output  COUNT_W  number of operands accepted in the sequence.
REQ-014 SHALL have port out_flags  output  3  {nan, inf, zero}, with nan sticky and inf/zero describing out_sum.

Function
REQ-015 SHALL have two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-016 SHALL feed the combinational adder with NumberA = acc register, NumberB = in_data, A_S = in_sub.
REQ-017 SHALL, in ACCUM on in_valid&in_ready, load acc with the adder Result and increment count in the same edge.
REQ-018 SHALL saturate count at 2^COUNT_W-1 with no wrap-around.
REQ-019 SHALL, when the accepted beat has in_last=1, move to HOLD so that out_valid rises the cycle after acceptance (latency 1), with out_sum equal to the updated acc.
REQ-020 SHALL hold out_sum, out_count and out_flags stable in HOLD until out_ready=1.
REQ-021 SHALL, in HOLD with out_ready=1, clear acc to +0, count to 0 and flags to 0, then return to ACCUM (in_ready is high on the next cycle, not the same cycle).
REQ-022 SHALL set the sticky nan flag when a Result has exponent 8'hFF and a nonzero mantissa, and thereafter force acc to the canonical NaN 32'hFF800001 for the rest of the sequence.
REQ-023 SHALL drive inf=1 when acc is ±infinity (exponent 8'hFF, mantissa 0) and zero=1 when acc[30:0]==0.
REQ-024 SHALL give clr priority over every handshake: it clears acc, count and flags and forces ACCUM; an in beat presented in the same cycle is not accepted (in_ready reads 0 while clr=1).
REQ-025 SHALL, on a single-operand sequence (first beat carries in_last), produce +0 ± in_data as the adder computes it.

Reset
REQ-026 SHALL, on rst_n low at any time, asynchronously set state to ACCUM, acc to 32'h00000000, count to 0 and flags to 0, with out_valid=0 and in_ready=1 after release.
REQ-027 SHALL discard any partial sequence or pending HOLD result when reset is asserted mid-operation.

Structure
REQ-028 SHALL take from shared package fp32_pkg: FP32_ZERO, FP32_QNAN (32'hFF800001), FP32_EXP_MAX (8'hFF), and the state enum.
REQ-029 SHALL contain exactly one sub-module, the existing combinational adder Final, instantiated once with no added pipeline stage.

Verification
REQ-030 SHALL verify: beats 32'h3F800000 (add), 32'h40000000 (add, last) -> out_sum 32'h40400000, count 2, flags 3'b000.
REQ-031 SHALL verify: single beat 32'h7EAAAAAA (last) -> out_sum 32'h7EAAAAAA, count 1.
REQ-032 SHALL verify: beats 32'hFF800000, 32'h7F800000 (last) -> out_sum 32'hFF800001, flags nan=1; a following 32'h3F800000 beat in the next sequence starts from +0.
REQ-033 SHALL verify: out_ready held low 3 cycles in HOLD -> outputs stable, in_ready=0, no beats accepted; the first cycle after the out_ready pulse has in_ready=1.
REQ-034 SHALL verify: clr asserted concurrent with in_valid mid-sequence -> beat not accepted, count 0, acc 0.
REQ-035 SHALL verify: rst_n pulsed low between edges while in HOLD -> out_valid drops immediately and state returns to ACCUM.
